// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM states, grant ids, bus widths
// and the contention pick rule.
package mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_e;

    // DM wins contention unless it was served last, so IF can never starve.
    function automatic arb_gnt_e arb_pick(input logic if_req, input logic dm_req,
                                          input arb_gnt_e last);
        if (dm_req && !(if_req && last == GNT_DM)) return GNT_DM;
        return GNT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF port, DM port and unified-memory port of the arbiter.
// slave = arbiter view, master = requesters plus memory.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module arb_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                        cnt_d = '0;
        else if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and data (DM) ports, one access
// at a time. Optional wait-cycle counters are built with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                stall_if,
    output logic                stall_dm
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    input  logic                perf_clr,
    output logic [31:0]         perf_if_wait,
    output logic [31:0]         perf_dm_wait
`endif
);

    arb_state_e    state_q, state_d;
    arb_gnt_e      gnt_q, gnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    gnt_d = arb_pick(bus.if_req, bus.dm_req, gnt_q);
                    if (gnt_d == GNT_DM) begin
                        state_d     = ARB_BUSY_D;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        state_d    = ARB_BUSY_I;
                        mem_we_d   = 1'b0;
                        mem_addr_d = bus.if_addr;
                    end
                end
            end
            ARB_BUSY_I: begin
                if (bus.mem_ready) begin
                    if_rdata_d = bus.mem_rdata;
                    state_d    = ARB_RESP;
                end
            end
            ARB_BUSY_D: begin
                if (bus.mem_ready) begin
                    if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Request and acks decode straight from state, so reset clears them at once.
    assign bus.mem_req   = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = (state_q == ARB_RESP) && (gnt_q == GNT_IF);
    assign bus.dm_ack    = (state_q == ARB_RESP) && (gnt_q == GNT_DM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;

    assign stall_if = bus.if_req & ~bus.if_ack;
    assign stall_dm = bus.dm_req & ~bus.dm_ack;

`ifdef MEM_ARB_PERF_CNT_EN
    arb_sat_counter #(.W(32)) u_perf_if (
        .clk   (clk),
        .reset (reset),
        .clr_i (perf_clr),
        .inc_i (stall_if),
        .cnt_o (perf_if_wait)
    );

    arb_sat_counter #(.W(32)) u_perf_dm (
        .clk   (clk),
        .reset (reset),
        .clr_i (perf_clr),
        .inc_i (stall_dm),
        .cnt_o (perf_dm_wait)
    );
`endif

    // A requester must keep req up while its access is in flight.
    a_if_req_held: assert property (@(posedge clk) disable iff (!reset)
        (state_q == ARB_BUSY_I) |-> bus.if_req);
    a_dm_req_held: assert property (@(posedge clk) disable iff (!reset)
        (state_q == ARB_BUSY_D) |-> bus.dm_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus two random requesters
// against a variable-latency memory, scored by a transaction-level model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAXW    = 3;
    localparam int LAT_MAX = 2 * MAXW + 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stall_if, stall_dm;
`ifdef MEM_ARB_PERF_CNT_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_if_wait, perf_dm_wait;
`endif

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .stall_if (stall_if),
        .stall_dm (stall_dm)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_clr     (perf_clr),
        .perf_if_wait (perf_if_wait),
        .perf_dm_wait (perf_dm_wait)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem_arr [256];
    logic [31:0] exp_mem [256];
    int          mem_wait  = 0;
    bit          rand_wait = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Memory: ready after a programmable number of wait cycles; noise on ready/rdata while idle.
    initial begin : mem_model
        int cnt;
        int cur;
        cnt = 0;
        cur = -1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!bus.mem_req) begin
                cnt = 0;
                cur = -1;
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = $urandom;
            end else begin
                if (cur < 0) cur = rand_wait ? int'($urandom_range(0, MAXW)) : mem_wait;
                if (cnt == cur) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];
                    if (bus.mem_we) mem_arr[bus.mem_addr[9:2]] = bus.mem_wdata;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                    cnt++;
                end
            end
        end
    end

    // Transaction-level scoreboard: grant choice, ack ownership, field stability, stalls.
    initial begin : monitor
        bit          pend;
        arb_gnt_e    pred, last;
        logic        prev_if, prev_dm, prev_mreq, pwe;
        logic [31:0] pa, pw, eiw, edw;
        pend = 1'b0; pred = GNT_IF; last = GNT_IF;
        prev_if = 1'b0; prev_dm = 1'b0; prev_mreq = 1'b0; pwe = 1'b0;
        pa = '0; pw = '0; eiw = '0; edw = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                pend = 1'b0; last = GNT_IF;
                prev_if = 1'b0; prev_dm = 1'b0; prev_mreq = 1'b0;
                eiw = '0; edw = '0;
                continue;
            end
            chk("stall_if", 32'(stall_if), 32'(bus.if_req && !bus.if_ack));
            chk("stall_dm", 32'(stall_dm), 32'(bus.dm_req && !bus.dm_ack));
            chk("dual_ack", 32'(bus.if_ack && bus.dm_ack), 32'(0));
            if (bus.mem_req && !prev_mreq) begin
                chk("grant_with_req", 32'(prev_if || prev_dm), 32'(1));
                if (prev_if && prev_dm) pred = (last == GNT_DM) ? GNT_IF : GNT_DM;
                else                    pred = prev_dm ? GNT_DM : GNT_IF;
                last = pred;
                pend = 1'b1;
                if (pred == GNT_IF) begin
                    chk("grant_if_addr", bus.mem_addr, bus.if_addr);
                    chk("grant_if_we", 32'(bus.mem_we), 32'(0));
                end else begin
                    chk("grant_dm_addr", bus.mem_addr, bus.dm_addr);
                    chk("grant_dm_we", 32'(bus.mem_we), 32'(bus.dm_we));
                    if (bus.dm_we) chk("grant_dm_wdata", bus.mem_wdata, bus.dm_wdata);
                end
            end else if (bus.mem_req) begin
                chk("hold_addr", bus.mem_addr, pa);
                chk("hold_we", 32'(bus.mem_we), 32'(pwe));
                chk("hold_wdata", bus.mem_wdata, pw);
            end
            if (bus.if_ack || bus.dm_ack) begin
                chk("ack_owed", 32'(pend), 32'(1));
                chk("ack_port", 32'(bus.dm_ack), 32'(pred == GNT_DM));
                pend = 1'b0;
            end
`ifdef MEM_ARB_PERF_CNT_EN
            chk("perf_if_wait", perf_if_wait, eiw);
            chk("perf_dm_wait", perf_dm_wait, edw);
            if (perf_clr) begin
                eiw = '0;
                edw = '0;
            end else begin
                if (stall_if && eiw != 32'hFFFF_FFFF) eiw = eiw + 1;
                if (stall_dm && edw != 32'hFFFF_FFFF) edw = edw + 1;
            end
`endif
            prev_if   = bus.if_req;
            prev_dm   = bus.dm_req;
            prev_mreq = bus.mem_req;
            pa        = bus.mem_addr;
            pw        = bus.mem_wdata;
            pwe       = bus.mem_we;
        end
    end

    task automatic if_agent(input int n);
        for (int t = 0; t < n; t++) begin
            int idx, lat;
            bit done;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            idx = int'($urandom_range(0, 127));
            bus.if_addr = 32'(idx * 4);
            bus.if_req  = 1'b1;
            lat = 0; done = 1'b0;
            while (!done && lat < 40) begin
                cyc();
                lat++;
                if (bus.if_ack) done = 1'b1;
            end
            chk("if_timeout", 32'(done), 32'(1));
            if (done) begin
                chk("if_latency", 32'(lat >= 2 && lat <= LAT_MAX), 32'(1));
                chk("if_rdata", bus.if_rdata, exp_mem[idx]);
            end
            bus.if_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic dm_agent(input int n);
        for (int t = 0; t < n; t++) begin
            int idx, lat;
            bit done;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            idx = int'($urandom_range(128, 255));
            bus.dm_addr  = 32'(idx * 4);
            bus.dm_we    = 1'($urandom);
            bus.dm_wdata = $urandom;
            bus.dm_req   = 1'b1;
            lat = 0; done = 1'b0;
            while (!done && lat < 40) begin
                cyc();
                lat++;
                if (bus.dm_ack) done = 1'b1;
            end
            chk("dm_timeout", 32'(done), 32'(1));
            if (done) begin
                chk("dm_latency", 32'(lat >= 2 && lat <= LAT_MAX), 32'(1));
                if (bus.dm_we) exp_mem[idx] = bus.dm_wdata;
                else           chk("dm_rdata", bus.dm_rdata, exp_mem[idx]);
            end
            bus.dm_req = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin : main
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            exp_mem[i] = mem_arr[i];
        end
        mem_arr[1] = 32'h2008_0005; exp_mem[1] = 32'h2008_0005;
        mem_arr[4] = 32'h0000_0007; exp_mem[4] = 32'h0000_0007;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

        // reset values
        repeat (2) cyc();
        chk("rst_mem_req", 32'(bus.mem_req), 32'(0));
        chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_acks", 32'({bus.if_ack, bus.dm_ack}), 32'(0));
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
        reset = 1'b1;
        cyc();

        // single IF read, zero wait
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        #1;
        chk("t1_c0_stall", 32'(stall_if), 32'(1));
        chk("t1_c0_mreq", 32'(bus.mem_req), 32'(0));
        cyc();
        chk("t1_c1_mreq", 32'(bus.mem_req), 32'(1));
        chk("t1_c1_maddr", bus.mem_addr, 32'h4);
        chk("t1_c1_mwe", 32'(bus.mem_we), 32'(0));
        chk("t1_c1_stall", 32'(stall_if), 32'(1));
        cyc();
        chk("t1_c2_ack", 32'(bus.if_ack), 32'(1));
        chk("t1_c2_rdata", bus.if_rdata, 32'h2008_0005);
        chk("t1_c2_mreq", 32'(bus.mem_req), 32'(0));
        bus.if_req = 1'b0;
        cyc();
        chk("t1_c3_ack", 32'(bus.if_ack), 32'(0));
        chk("t1_c3_rdata_held", bus.if_rdata, 32'h2008_0005);

        // load-use: DM read wins while IF waits
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
        cyc();
        chk("t2_c1_maddr", bus.mem_addr, 32'h10);
        chk("t2_c1_stall_if", 32'(stall_if), 32'(1));
        cyc();
        chk("t2_c2_dm_ack", 32'(bus.dm_ack), 32'(1));
        chk("t2_c2_dm_rdata", bus.dm_rdata, 32'h7);
        chk("t2_c2_stall_if", 32'(stall_if), 32'(1));
        bus.dm_req = 1'b0;
        cyc();
        chk("t2_c3_mreq", 32'(bus.mem_req), 32'(0));
        chk("t2_c3_stall_if", 32'(stall_if), 32'(1));
        cyc();
        chk("t2_c4_maddr", bus.mem_addr, 32'h8);
        cyc();
        chk("t2_c5_if_ack", 32'(bus.if_ack), 32'(1));
        chk("t2_c5_if_rdata", bus.if_rdata, exp_mem[2]);
        bus.if_req = 1'b0;
        cyc();

        // DM write, three wait states
        mem_wait = 3;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
        exp_mem[16] = 32'hDEAD_BEEF;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("t3_mreq", 32'(bus.mem_req), 32'(1));
            chk("t3_maddr", bus.mem_addr, 32'h40);
            chk("t3_mwdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("t3_mwe", 32'(bus.mem_we), 32'(1));
            chk("t3_no_ack", 32'(bus.dm_ack), 32'(0));
        end
        cyc();
        chk("t3_ack", 32'(bus.dm_ack), 32'(1));
        chk("t3_rdata_kept", bus.dm_rdata, 32'h7);
        chk("t3_mreq_drop", 32'(bus.mem_req), 32'(0));
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        mem_wait = 0;
        cyc();

        // continuous contention from reset release: DM, IF, DM, IF
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'hC;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h204;
        cyc();
        reset = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            chk("t4_dm_ack", 32'(bus.dm_ack), 32'(c % 6 == 2));
            chk("t4_if_ack", 32'(bus.if_ack), 32'(c % 6 == 5));
            if (c == 2) chk("t4_dm_rdata", bus.dm_rdata, exp_mem[129]);
            if (c == 5) chk("t4_if_rdata", bus.if_rdata, exp_mem[3]);
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        cyc();

        // reset in the middle of a DM access
        mem_wait = 3;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h208;
        cyc();
        chk("t5_mreq", 32'(bus.mem_req), 32'(1));
        cyc();
        #2;
        reset = 1'b0;
        #1;
        chk("t5_mreq_async", 32'(bus.mem_req), 32'(0));
        chk("t5_acks_async", 32'({bus.if_ack, bus.dm_ack}), 32'(0));
        chk("t5_if_rdata", bus.if_rdata, 32'h0);
        chk("t5_dm_rdata", bus.dm_rdata, 32'h0);
        chk("t5_maddr", bus.mem_addr, 32'h0);
        chk("t5_mwdata", bus.mem_wdata, 32'h0);
        bus.dm_req = 1'b0;
        cyc();
        reset = 1'b1;
        mem_wait = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk("t5_no_late_ack", 32'(bus.dm_ack), 32'(0));
            chk("t5_no_mreq", 32'(bus.mem_req), 32'(0));
        end

`ifdef MEM_ARB_PERF_CNT_EN
        // wait counters under contention, then a synchronous clear
        bus.if_req = 1'b1; bus.if_addr = 32'h14;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h220;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            if (c == 6) begin
                perf_clr = 1'b0;
                chk("perf_clr_if", perf_if_wait, 32'h0);
                chk("perf_clr_dm", perf_dm_wait, 32'h0);
            end
            if (c == 5) perf_clr = 1'b1;
            if (bus.if_ack) bus.if_req = 1'b0;
            if (bus.dm_ack) bus.dm_req = 1'b0;
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        cyc();
`endif

        // random traffic from both ports with random memory latency
        rand_wait = 1'b1;
        fork
            if_agent(40);
            dm_agent(40);
        join
        rand_wait = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch-stage instruction port (IF) and the memory-stage data port (DM) of the five-stage pipeline.
- Each port uses a req/ack handshake and sees a variable-latency memory (mem_ready).
- Produces per-port stall indications that the hazard logic ORs into StallF/StallD and the M-stage hold.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  instruction fetch request, level, held until if_ack
- if_addr  input  AW  fetch address, stable while if_req high
- if_rdata  output  DW  fetched instruction, valid when if_ack=1, held until next IF ack
- if_ack  output  1  one-cycle completion pulse, IF
- dm_req  input  1  data request, level, held until dm_ack
- dm_we  input  1  1=write, 0=read
- dm_addr  input  AW  data address
- dm_wdata  input  DW  write data
- dm_rdata  output  DW  read data, valid when dm_ack=1 on a read, held until next DM read ack
- dm_ack  output  1  one-cycle completion pulse, DM
- mem_req  output  1  memory request, held until mem_ready sampled
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion, sampled only while mem_req=1
- stall_if  output  1  if_req & ~if_ack
- stall_dm  output  1  dm_req & ~dm_ack

Behaviour:
- Reset: asynchronous, active-low (reset=0) forces:
  - state IDLE, last_grant=IF
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0
- Reset mid-transaction abandons the memory access; no ack is ever issued for it.
- FSM, 2-bit encoding: IDLE=0, BUSY_I=1, BUSY_D=2, RESP=3.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If only one request is pending, grant it.
  - If both are pending, grant DM, unless last_grant=DM, in which case grant IF. This alternates under continuous contention, and IF cannot starve.
  - On grant, register the address, we and wdata (DM only) into the mem_* outputs, set last_grant, and go to BUSY_x.
- BUSY_I / BUSY_D:
  - mem_req=1; mem_addr/mem_we/mem_wdata held stable.
  - mem_we=0 always for IF.
  - When mem_ready=1, capture mem_rdata into if_rdata or dm_rdata. DM writes leave dm_rdata unchanged.
  - On that same edge, drop mem_req, set the granted port's ack, and go to RESP.
- RESP:
  - Ack=1 for exactly this cycle; mem_req=0; go to IDLE.
  - Requests are ignored in this cycle. The requester sees ack and may present a new address/req from the next cycle.
- Latency: a request first sampled in IDLE at edge N gives mem_req from cycle N+1. With mem_ready=1 at N+1, ack is high in cycle N+2. The minimum is 2 cycles, plus each extra memory wait cycle.
- Back-to-back: the earliest re-grant is the cycle after RESP, so there is at most one transaction every 3 cycles.
- Simultaneous req on the same edge that the other port's RESP ends: handled by IDLE arbitration on the next edge.
- Requester withdrawing req before ack is illegal. An assertion flags it; the transaction still completes internally, and the ack is still pulsed.
- mem_ready while mem_req=0 is ignored.
- stall_if and stall_dm are combinational, with no register delay.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_if_wait[31:0] and perf_dm_wait[31:0].
  - Each increments on every cycle its stall_x=1, saturates at 32'hFFFFFFFF, and resets to 0.
  - Adds input perf_clr (synchronous clear, priority over increment).
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header mem_arb_pkg:
  - state encodings ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_RESP
  - grant IDs GNT_IF=0, GNT_DM=1
  - AW/DW defaults
- Sub-module: arb_sat_counter (32-bit saturating counter with clr/inc), instantiated twice only under MEM_ARB_PERF_CNT_EN.
- FSM and muxing stay in mem_port_arbiter.

Test Plan:
- Single IF read: if_req=1, if_addr=0x0000_0004, mem_ready=1 immediately, mem_rdata=0x2008_0005 -> mem_req in cycle 1 with mem_addr=0x4, mem_we=0; if_ack one pulse in cycle 2 with if_rdata=0x2008_0005; stall_if=1 in cycles 0-1.
- DM write with 3 wait states: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEAD_BEEF -> mem_req held 4 cycles, address/data stable; dm_ack 1 cycle after mem_ready; dm_rdata unchanged.
- Contention: if_req and dm_req both high from reset release, memory zero-wait -> grant order DM, IF, DM, IF; each ack 3 cycles apart; neither port waits more than 6 cycles.
- Reset mid-BUSY_D: assert reset=0 while mem_req=1 -> mem_req=0 and all acks/rdata 0 immediately (asynchronously); no ack follows after reset release.
- Load-use style: dm read of 0x10 returning 0x0000_0007 while IF is waiting -> dm_rdata=0x7 with dm_ack, then IF granted next IDLE cycle; stall_if high throughout.
- MEM_ARB_PERF_CNT_EN: 5 contended cycles then perf_clr=1 -> counters equal their stall-cycle counts, then 0 the cycle after perf_clr; force near 32'hFFFFFFFF and confirm saturation.
